// File: rtl/pipelined_mult_unit.sv
// Pipelined WIDTH x WIDTH multiplier with valid/ready flow control and per-transaction signed mode.
// Optional feature: define MULT_ACC_EN to add the accumulate port and the output accumulator.
module pipelined_mult_unit #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               is_signed,
`ifdef MULT_ACC_EN
    input  logic               accumulate,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] S
);

    localparam int PW   = 2 * WIDTH;
    localparam int ROWS = (PW + STAGES - 1) / STAGES;

    logic [STAGES:1] v_q, v_d, load, stage_rdy;
    logic [PW-1:0]   a_q     [1:STAGES];
    logic [PW-1:0]   a_d     [1:STAGES];
    logic [PW-1:0]   b_q     [1:STAGES];
    logic [PW-1:0]   b_d     [1:STAGES];
    logic [PW-1:0]   sum_q   [1:STAGES];
    logic [PW-1:0]   sum_d   [1:STAGES];
    logic [PW-1:0]   carry_q [1:STAGES];
    logic [PW-1:0]   carry_d [1:STAGES];

    // Index 0 of the *_pre arrays is the operand port; index i is register stage i.
    logic [STAGES-1:0] v_pre;
    logic [PW-1:0]     a_pre [0:STAGES-1];
    logic [PW-1:0]     b_pre [0:STAGES-1];
    logic [PW-1:0]     s_pre [0:STAGES-1];
    logic [PW-1:0]     c_pre [0:STAGES-1];
    logic              fire_out;

`ifdef MULT_ACC_EN
    logic          accum_q   [1:STAGES];
    logic          accum_d   [1:STAGES];
    logic          accum_pre [0:STAGES-1];
    logic [PW-1:0] acc_q;
    logic [PW-1:0] acc_eff;
`endif

    function automatic logic [PW-1:0] extend(input logic [WIDTH-1:0] x, input logic sgn);
        return sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
    endfunction

    // A stage may load if any stage from it to the output has a free slot, or the output drains.
    always_comb begin
        stage_rdy = '0;
        for (int i = 1; i <= STAGES; i++) begin
            stage_rdy[i] = out_ready;
            for (int j = i; j <= STAGES; j++) begin
                if (!v_q[j]) stage_rdy[i] = 1'b1;
            end
        end
    end

    assign in_ready  = stage_rdy[1] && !rst;
    assign out_valid = v_q[STAGES];
    assign S         = sum_q[STAGES];
    assign fire_out  = v_q[STAGES] && out_ready;

    always_comb begin
        v_pre    = '0;
        v_pre[0] = in_valid && in_ready;
        a_pre[0] = extend(A, is_signed);
        b_pre[0] = extend(B, is_signed);
        s_pre[0] = '0;
        c_pre[0] = '0;
`ifdef MULT_ACC_EN
        accum_pre[0] = accumulate;
`endif
        for (int i = 1; i < STAGES; i++) begin
            v_pre[i] = v_q[i];
            a_pre[i] = a_q[i];
            b_pre[i] = b_q[i];
            s_pre[i] = sum_q[i];
            c_pre[i] = carry_q[i];
`ifdef MULT_ACC_EN
            accum_pre[i] = accum_q[i];
`endif
        end
    end

    // Each stage folds its share of partial-product rows into a carry-save pair; the last
    // stage also resolves the pair with the carry-propagate add.
    always_comb begin
        logic [PW-1:0] s_x, c_x, pp, b_sh, maj;
        // NOTE: defaults on every path keep this block free of inferred latches.
        v_d  = '0;
        load = '0;
        s_x  = '0;
        c_x  = '0;
        pp   = '0;
        b_sh = '0;
        maj  = '0;
`ifdef MULT_ACC_EN
        acc_eff = fire_out ? sum_q[STAGES] : acc_q;
`endif
        for (int i = 1; i <= STAGES; i++) begin
            s_x = s_pre[i-1];
            c_x = c_pre[i-1];
            for (int k = 0; k < ROWS; k++) begin
                if ((i - 1) * ROWS + k < PW) begin
                    // NOTE: blocking updates here chain the 3:2 compressors within one cycle.
                    b_sh = b_pre[i-1] >> ((i - 1) * ROWS + k);
                    pp   = b_sh[0] ? (a_pre[i-1] << ((i - 1) * ROWS + k)) : '0;
                    maj  = (s_x & c_x) | (s_x & pp) | (c_x & pp);
                    s_x  = s_x ^ c_x ^ pp;
                    c_x  = maj << 1;
                end
            end
            v_d[i]  = stage_rdy[i] ? v_pre[i-1] : v_q[i];
            load[i] = stage_rdy[i] && v_pre[i-1];
            a_d[i]  = a_pre[i-1];
            b_d[i]  = b_pre[i-1];
`ifdef MULT_ACC_EN
            accum_d[i] = accum_pre[i-1];
`endif
            if (i == STAGES) begin
`ifdef MULT_ACC_EN
                sum_d[i] = s_x + c_x + (accum_pre[i-1] ? acc_eff : '0);
`else
                sum_d[i] = s_x + c_x;
`endif
                carry_d[i] = '0;
            end else begin
                sum_d[i]   = s_x;
                carry_d[i] = c_x;
            end
        end
    end

    // NOTE: data registers are cleared too, not only valid bits, so S reads 0 out of reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 1; i <= STAGES; i++) begin
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                sum_q[i]   <= '0;
                carry_q[i] <= '0;
`ifdef MULT_ACC_EN
                accum_q[i] <= 1'b0;
`endif
            end
`ifdef MULT_ACC_EN
            acc_q <= '0;
`endif
        end else begin
            v_q <= v_d;
            for (int i = 1; i <= STAGES; i++) begin
                if (load[i]) begin
                    a_q[i]     <= a_d[i];
                    b_q[i]     <= b_d[i];
                    sum_q[i]   <= sum_d[i];
                    carry_q[i] <= carry_d[i];
`ifdef MULT_ACC_EN
                    accum_q[i] <= accum_d[i];
`endif
                end
            end
`ifdef MULT_ACC_EN
            if (fire_out) acc_q <= sum_q[STAGES];
`endif
        end
    end

endmodule

// File: tb/tb_pipelined_mult_unit.sv
// Self-checking bench for pipelined_mult_unit: queue-based reference model plus directed vectors.
// The accumulate scenario is compiled in only when MULT_ACC_EN is defined.
module tb_pipelined_mult_unit;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int PW     = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             is_signed;
    logic             accumulate;
    logic             out_valid;
    logic             out_ready;
    logic [PW-1:0]    S;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipelined_mult_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .is_signed (is_signed),
`ifdef MULT_ACC_EN
        .accumulate(accumulate),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S)
    );

    typedef struct {
        logic [PW-1:0] prod;
        logic          accum;
        int            cyc;
    } txn_t;

    txn_t          exp_q[$];
    logic [PW-1:0] obs_s[$];
    int            obs_cyc[$];
    int            obs_lat[$];
    int            cyc   = 0;
    int            n_acc = 0;
    logic [PW-1:0] macc  = '0;
    logic [PW-1:0] prev_s = '0;
    logic          prev_stall = 1'b0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_product(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                  input logic sg);
        longint sa, sb;
        if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return sa * sb;
        end
        return {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    endfunction

    // Monitor: samples both handshakes on the falling edge and scores every output transfer.
    always @(negedge clk) begin
        txn_t          t;
        logic [PW-1:0] want;
        cyc++;
        if (rst) begin
            exp_q.delete();
            macc       = '0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", {63'b0, out_valid}, 64'd1);
                check("stall_S_hold", S, prev_s);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", {63'b0, out_valid}, 64'd0);
                end else begin
                    t    = exp_q.pop_front();
                    want = t.accum ? macc + t.prod : t.prod;
                    macc = want;
                    check("model_S", S, want);
                    obs_s.push_back(S);
                    obs_cyc.push_back(cyc);
                    obs_lat.push_back(cyc - t.cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = S;
            if (in_valid && in_ready) begin
                t.prod  = ref_product(A, B, is_signed);
                t.accum = accumulate;
                t.cyc   = cyc;
                exp_q.push_back(t);
                n_acc++;
            end
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sg,
                        input logic ac);
        bit done = 1'b0;
        in_valid   = 1'b1;
        A          = a;
        B          = b;
        is_signed  = sg;
        accumulate = ac;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
        end
        if (!done) check("send_timeout_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit t3_done = 1'b0;

    initial begin
        int base;
        int acc0;
        bit stale;

        rst        = 1'b1;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        is_signed  = 1'b0;
        accumulate = 1'b0;
        out_ready  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check("rst_S", S, 64'd0);
        check("rst_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {63'b0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Single transaction: product, latency of STAGES cycles, one output beat
        base = obs_s.size();
        send(32'd1021, 32'd10000000, 1'b0, 1'b0);
        cycles(8);
        check("t1_count", 64'(obs_s.size() - base), 64'd1);
        check("t1_S", obs_s[base], 64'd10210000000);
        check("t1_latency", 64'(obs_lat[base]), 64'(STAGES));
        @(negedge clk);
        check("t1_valid_low", {63'b0, out_valid}, 64'd0);
        @(posedge clk);
        #1;

        // Back-to-back, mixed signedness
        base = obs_s.size();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        send(32'hFFFF_FFFD, 32'd7,         1'b1, 1'b0);
        cycles(8);
        check("t2_S0", obs_s[base],     64'hFFFF_FFFE_0000_0001);
        check("t2_S1", obs_s[base + 1], 64'h0000_0000_0000_0001);
        check("t2_S2", obs_s[base + 2], 64'hFFFF_FFFF_FFFF_FFEB);
        check("t2_consecutive", 64'(obs_cyc[base + 2] - obs_cyc[base]), 64'd2);

        // Back-pressure: fill the pipe with out_ready low, then drain
        out_ready = 1'b0;
        base      = obs_s.size();
        acc0      = n_acc;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0);
                t3_done = 1'b1;
            end
        join_none
        cycles(10);
        @(negedge clk);
        check("t3_in_ready_full", {63'b0, in_ready}, 64'd0);
        check("t3_accepted", 64'(n_acc - acc0), 64'd4);
        check("t3_out_valid", {63'b0, out_valid}, 64'd1);
        check("t3_S_held", S, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int n = 0; n < 100 && !t3_done; n++) @(posedge clk);
        check("t3_done", {63'b0, t3_done}, 64'd1);
        cycles(8);
        for (int i = 0; i < 6; i++) check("t3_order", obs_s[base + i], 64'((i + 1) * (i + 1)));
        check("t3_no_gaps", 64'(obs_cyc[base + 5] - obs_cyc[base]), 64'd5);

        // Signed / unsigned corners
        base = obs_s.size();
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h8000_0000, 32'd1,         1'b1, 1'b0);
        cycles(8);
        check("t4_minxmin_signed",   obs_s[base],     64'h4000_0000_0000_0000);
        check("t4_minxmin_unsigned", obs_s[base + 1], 64'h4000_0000_0000_0000);
        check("t4_minx1_signed",     obs_s[base + 2], 64'hFFFF_FFFF_8000_0000);

        // Reset with three transactions in flight
        base = obs_s.size();
        send(32'd7, 32'd7, 1'b0, 1'b0);
        send(32'd8, 32'd8, 1'b0, 1'b0);
        send(32'd9, 32'd9, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        stale = 1'b0;
        repeat (STAGES + 2) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("t5_no_stale", {63'b0, stale}, 64'd0);
        @(posedge clk);
        #1;
        send(32'd2, 32'd3, 1'b0, 1'b0);
        cycles(8);
        check("t5_count", 64'(obs_s.size() - base), 64'd1);
        check("t5_S", obs_s[base], 64'd6);

`ifdef MULT_ACC_EN
        // Accumulate chain
        base = obs_s.size();
        send(32'd3, 32'd4, 1'b0, 1'b0);
        send(32'd5, 32'd6, 1'b0, 1'b1);
        send(32'd2, 32'd2, 1'b0, 1'b1);
        cycles(8);
        check("t6_S0", obs_s[base],     64'd12);
        check("t6_S1", obs_s[base + 1], 64'd42);
        check("t6_S2", obs_s[base + 2], 64'd46);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipelined_mult_unit.md
# pipelined_mult_unit

Parametrised, fully pipelined integer multiplier with valid/ready handshakes on both sides, per-transaction signed/unsigned selection and a configurable number of register stages. It is the successor to the fixed 32x32 Wallace-tree multiplier. It adds back-pressure, signed mode and width/depth generics. The block sits between an operand-issue stage and a result write-back consumer, and sustains one product per cycle when unstalled.

## Interface
- WIDTH, 32, operand width in bits (>= 4)
- STAGES, 4, number of pipeline register stages from input to output (>= 1)

- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair presented
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  multiplicand
- B  input  WIDTH  multiplier
- is_signed  input  1  1: A, B and S two's complement; 0: unsigned
- out_valid  output  1  S holds a valid product
- out_ready  input  1  consumer takes S this cycle
- S  output  2*WIDTH  product

## Operation
- Transfer in: the cycle with in_valid && in_ready. A, B and is_signed are captured into stage 1.
- Transfer out: the cycle with out_valid && out_ready.
- Per-stage valid bit v[i], i = 1..STAGES. ready[i] = !v[i] || ready[i+1]. ready[STAGES+1] = out_ready. in_ready = ready[1] && !rst.
- Stage i loads from stage i-1 when ready[i]. When stage i-1 is not valid, v[i] clears.
- Bubbles collapse: a stalled output does not block upstream stages that have an empty slot ahead.
- Arithmetic: S equals the exact 2*WIDTH-bit product, with no truncation or overflow possible.
  - Unsigned: both operands are zero-extended.
  - Signed: both operands are sign-extended. Most-negative × most-negative gives +2^(2*WIDTH-2).
- Partial-product generation and carry-save (Wallace) reduction are distributed across the stages. The final carry-propagate add happens in the last stage.
- Any internal partitioning is allowed, provided there are exactly STAGES register stages on the data path.
- is_signed travels with its operands, so mixed-mode back-to-back transactions are legal.
- Order is strictly preserved. No transaction is dropped or duplicated.

## Timing
- Latency: a transfer in at clock edge k gives out_valid = 1 after edge k+STAGES, provided the output stage is free by then.
- Throughput: 1 transaction/cycle while out_ready = 1.
- in_ready depends combinationally on out_ready. in_valid and out_valid depend only on registers, so there is no combinational in_valid→out_valid path.
- While out_valid && !out_ready, S and out_valid hold stable.
- Full pipeline (all v = 1) with out_ready = 0 forces in_ready = 0.
- Same-cycle transfer in and transfer out on a full pipeline is legal: every stage shifts.
- Reset values, applied on the edge where rst = 1: every v[i] = 0, out_valid = 0, S = 0.
  - in_ready = 0 while rst = 1, and 1 in the first cycle after.
- Reset mid-operation discards all in-flight transactions. No stale product appears afterward.

## Configuration
- MULT_ACC_EN defined:
  - Adds port `accumulate  input  1`, captured with the operands, and an internal 2*WIDTH accumulator register, acc.
  - At output transfer: if accumulate = 1, S = acc + product (mod 2^(2*WIDTH)), else S = product.
  - acc is updated to the presented S on every transfer out.
  - The addition is done in the last stage, so latency is unchanged. rst clears acc to 0.
  - Held S stays stable during a stall; acc updates only on the transfer cycle.
- MULT_ACC_EN undefined: no accumulate port and no acc register. Behaviour is exactly as above.

## Test plan
- WIDTH=32, STAGES=4, out_ready=1, unsigned A=1021, B=10000000 → S=10210000000, out_valid for one cycle, 4 cycles after acceptance.
- Back-to-back: unsigned 0xFFFFFFFF×0xFFFFFFFF, then signed 0xFFFFFFFF×0xFFFFFFFF, then signed 0xFFFFFFFD×7. Required S sequence: 0xFFFFFFFE00000001, then 1, then 0xFFFFFFFFFFFFFFEB, on three consecutive cycles.
- Back-pressure:
  - Issue 6 transactions 1×1 .. 6×6 with out_ready=0. in_ready drops after 4 are accepted, and S=1 holds.
  - Release out_ready. Results 1, 4, 9, 16, 25, 36 appear in order with no gaps or duplicates.
- Signed corner: A=B=0x80000000 signed → S=0x4000000000000000. Unsigned → 0x4000000000000000. A=0x80000000, B=1 signed → 0xFFFFFFFF80000000.
- Reset mid-flight: accept 3 transactions, assert rst for 1 cycle → out_valid stays 0 for ≥ STAGES cycles after. A new 2×3 then yields S=6.
- MULT_ACC_EN: 3×4 with accumulate=0, then 5×6 with accumulate=1, then 2×2 with accumulate=1 → S = 12, 42, 46.
